// File: rtl/owt_rx_pkg.sv
// Shared types and constants for the OWT receive-side frame controller.
package owt_rx_pkg;

  // Frame sequencer states: sync hunt, payload capture, parity symbol.
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } owt_rx_st_e;

  // Parity select: 1 = even parity. Odd parity is reserved for future use.
  localparam logic OWT_PAR_EVEN = 1'b1;

endpackage : owt_rx_pkg

// File: rtl/owt_rx_ctrl.sv
// OWT receive frame controller.
//
// Takes decoded 0/1 symbols from the run-length symbol detector. It hunts
// for a run of SYNC_LEN or more '1' symbols followed by a '0' start bit. It
// then captures DATA_W payload bits (MSB first) and one even-parity bit, and
// hands the frame to the consumer through a one-entry output buffer.
//
// Output handshake: o_frm_vld/o_frm_data/o_frm_err form a valid/ready
// channel. A frame transfers on every clock edge where o_frm_vld & i_frm_rdy.
// While o_frm_vld is high and the frame has not transferred, data and err are
// held stable. o_frm_vld never depends combinationally on i_frm_rdy. A
// parity symbol arriving in the same cycle as a transfer reloads the buffer,
// so o_frm_vld stays high. A frame that completes while the buffer is still
// occupied (and not transferring) is dropped and flagged on o_ovf.
//
// The FSM state is visible as st_q for hierarchical probing.
module owt_rx_ctrl
  import owt_rx_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_LEN = 4,
  parameter int                TMO_W    = 12,
  parameter logic [TMO_W-1:0]  TMO_TH   = TMO_W'(1000)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_sym_vld,
  input  logic              i_sym_data,
  output logic              o_frm_vld,
  output logic [DATA_W-1:0] o_frm_data,
  output logic              o_frm_err,
  input  logic              i_frm_rdy,
  output logic              o_tmo,
  output logic              o_ovf,
  output logic              o_busy
);

  localparam int BIT_W  = $clog2(DATA_W);
  localparam int SYNC_W = $clog2(SYNC_LEN + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [SYNC_W-1:0] SYNC_FULL = SYNC_W'(SYNC_LEN);
  localparam logic [TMO_W-1:0]  GAP_LAST  = TMO_TH - TMO_W'(1);

  owt_rx_st_e         st_q;
  owt_rx_st_e         st_d;
  logic [SYNC_W-1:0]  sync_q;
  logic [BIT_W-1:0]   bit_q;
  logic [TMO_W-1:0]   gap_q;
  logic [DATA_W-1:0]  shreg_q;

  logic sym_evt;
  logic start_evt;
  logic par_evt;
  logic tmo_evt;
  logic buf_free;
  logic par_exp;
  logic par_err;

  // Symbols only count while enabled; a disabled controller ignores input.
  assign sym_evt   = i_en & i_sym_vld;
  // A '0' after a full preamble is the start bit.
  assign start_evt = (st_q == HUNT) & sym_evt & ~i_sym_data & (sync_q == SYNC_FULL);
  assign par_evt   = (st_q == PAR) & sym_evt;
  // A symbol in the same cycle as the last gap count wins over the timeout.
  assign tmo_evt   = i_en & (st_q != HUNT) & ~i_sym_vld & (gap_q == GAP_LAST);
  // Buffer can accept a new frame when empty or draining this cycle.
  assign buf_free  = ~o_frm_vld | i_frm_rdy;
  assign par_exp   = (^shreg_q) ^ ~OWT_PAR_EVEN;
  assign par_err   = par_exp ^ i_sym_data;

  // FSM state register plus the sync, bit and gap counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q   <= HUNT;
      sync_q <= '0;
      bit_q  <= '0;
      gap_q  <= '0;
    end else begin
      st_q <= st_d;
      if (!i_en) begin
        sync_q <= '0;
        bit_q  <= '0;
        gap_q  <= '0;
      end else begin
        // Preamble run length: only meaningful while hunting, saturates.
        if ((st_q != HUNT) || (st_d != HUNT)) begin
          sync_q <= '0;
        end else if (sym_evt) begin
          if (!i_sym_data)
            sync_q <= '0;
          else if (sync_q != SYNC_FULL)
            sync_q <= sync_q + SYNC_W'(1);
        end
        // Payload bit index; restarts at zero whenever outside DATA.
        if ((st_q == DATA) && sym_evt)
          bit_q <= (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
        else if (st_q != DATA)
          bit_q <= '0;
        // Inter-symbol gap: cleared on symbols and state changes, stops at the limit.
        if ((st_d == HUNT) || (st_d != st_q) || i_sym_vld)
          gap_q <= '0;
        else if (gap_q != GAP_LAST)
          gap_q <= gap_q + TMO_W'(1);
      end
    end
  end

  // Next-state logic; a low enable always returns to HUNT.
  always_comb begin
    st_d = st_q;
    case (st_q)
      HUNT: if (start_evt) st_d = DATA;
      DATA: begin
        if (tmo_evt)                          st_d = HUNT;
        else if (sym_evt && bit_q == BIT_LAST) st_d = PAR;
      end
      PAR:  if (tmo_evt || par_evt) st_d = HUNT;
      default: st_d = HUNT;
    endcase
    if (!i_en) st_d = HUNT;
  end

  // Status outputs derived from the current state.
  always_comb begin
    o_busy = (st_q != HUNT);
  end

  // Payload shift register: first received bit ends up in the MSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      shreg_q <= '0;
    else if (!i_en || start_evt)
      shreg_q <= '0;
    else if ((st_q == DATA) && sym_evt)
      shreg_q <= {shreg_q[DATA_W-2:0], i_sym_data};
  end

  // One-entry output buffer and the registered timeout/overflow pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frm_vld  <= 1'b0;
      o_frm_data <= '0;
      o_frm_err  <= 1'b0;
      o_tmo      <= 1'b0;
      o_ovf      <= 1'b0;
    end else begin
      o_tmo <= tmo_evt;
      o_ovf <= par_evt & ~buf_free;
      if (par_evt && buf_free) begin
        o_frm_vld  <= 1'b1;
        o_frm_data <= shreg_q;
        o_frm_err  <= par_err;
      end else if (i_frm_rdy) begin
        o_frm_vld  <= 1'b0;
      end
    end
  end

`ifdef ASSERT_ON
  a_tmo_th_min: assert property (@(posedge i_clk) TMO_TH >= TMO_W'(1));
  a_sync_min:   assert property (@(posedge i_clk) SYNC_LEN >= 1);
  a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_frm_vld && !i_frm_rdy) |=> ($stable(o_frm_data) && $stable(o_frm_err)));
`endif

endmodule : owt_rx_ctrl

// File: tb/tb_owt_rx_ctrl.sv
// Directed bench for owt_rx_ctrl. A symbol-level reference model, written in
// terms of preamble runs, collected-bit queues and idle-cycle counts, is
// compared against every DUT output on each falling edge. Accepted frames are
// also matched against hand-computed literals queued in exp_q.
module tb_owt_rx_ctrl;

  localparam int          DATA_W   = 8;
  localparam int          SYNC_LEN = 4;
  localparam int          TMO_W    = 12;
  localparam int          TMO_TH   = 16;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              sym_vld;
  logic              sym_data;
  logic              frm_vld;
  logic [DATA_W-1:0] frm_data;
  logic              frm_err;
  logic              frm_rdy;
  logic              tmo;
  logic              ovf;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;
  int tmo_cnt  = 0;
  int ovf_cnt  = 0;

  // Expected accepted frames, {err, data}, pushed by the directed tests.
  logic [DATA_W:0] exp_q[$];

  owt_rx_ctrl #(
    .DATA_W  (DATA_W),
    .SYNC_LEN(SYNC_LEN),
    .TMO_W   (TMO_W),
    .TMO_TH  (TMO_W'(TMO_TH))
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_sym_vld (sym_vld),
    .i_sym_data(sym_data),
    .o_frm_vld (frm_vld),
    .o_frm_data(frm_data),
    .o_frm_err (frm_err),
    .i_frm_rdy (frm_rdy),
    .o_tmo     (tmo),
    .o_ovf     (ovf),
    .o_busy    (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic              m_vld;
  logic [DATA_W-1:0] m_data;
  logic              m_err;
  logic              m_tmo;
  logic              m_ovf;
  bit                in_frame;
  int                ones_run;
  int                idle;
  int                rx_bits[$];
  bit                loaded;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld = 0; m_data = '0; m_err = 0; m_tmo = 0; m_ovf = 0;
      in_frame = 0; ones_run = 0; idle = 0; rx_bits.delete();
    end else begin
      loaded = 0;
      m_tmo  = 0;
      m_ovf  = 0;
      if (!en) begin
        in_frame = 0; ones_run = 0; idle = 0; rx_bits.delete();
      end else if (!in_frame) begin
        if (sym_vld) begin
          if (sym_data) begin
            if (ones_run < SYNC_LEN) ones_run++;
          end else if (ones_run >= SYNC_LEN) begin
            in_frame = 1; idle = 0; rx_bits.delete();
          end else begin
            ones_run = 0;
          end
        end
      end else begin
        if (sym_vld) begin
          idle = 0;
          rx_bits.push_back(int'(sym_data));
          if (rx_bits.size() == DATA_W + 1) begin
            int ones;
            logic [DATA_W-1:0] d;
            ones = 0; d = '0;
            for (int i = 0; i < DATA_W; i++) begin
              d = {d[DATA_W-2:0], rx_bits[i][0]};
              ones += rx_bits[i];
            end
            if (!m_vld || frm_rdy) begin
              m_vld = 1; m_data = d; m_err = ((ones + rx_bits[DATA_W]) % 2) != 0;
              loaded = 1;
            end else begin
              m_ovf = 1;
            end
            in_frame = 0; ones_run = 0; rx_bits.delete();
          end
        end else begin
          idle++;
          if (idle == TMO_TH) begin
            m_tmo = 1; in_frame = 0; ones_run = 0; rx_bits.delete();
          end
        end
      end
      if (m_vld && frm_rdy && !loaded && !(m_vld === 1'b1 && loaded)) begin
        // Transfer completed this edge with no reload.
        if (!loaded) m_vld = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("frm_vld", 32'(frm_vld), 32'(m_vld));
      chk("frm_data", 32'(frm_data), 32'(m_data));
      chk("frm_err", 32'(frm_err), 32'(m_err));
      chk("tmo", 32'(tmo), 32'(m_tmo));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("busy", 32'(busy), 32'(in_frame));
      if (tmo) tmo_cnt++;
      if (ovf) ovf_cnt++;
    end
  end

  // ---------------- accepted-frame scoreboard ----------------
  always @(posedge clk) begin
    if (rst_n && frm_vld && frm_rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 32'({frm_err, frm_data}), 32'h1ff);
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        chk("accepted_frame", 32'({frm_err, frm_data}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sym(input logic b);
    @(negedge clk);
    sym_vld  = 1'b1;
    sym_data = b;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      sym_vld  = 1'b0;
      sym_data = 1'b0;
    end
  endtask

  // Preamble, start bit and the first nbits payload bits of d.
  task automatic send_head(input logic [DATA_W-1:0] d, input int nbits);
    for (int i = 0; i < SYNC_LEN; i++) sym(1'b1);
    sym(1'b0);
    for (int i = 0; i < nbits; i++) sym(d[DATA_W-1-i]);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p);
    send_head(d, DATA_W);
    sym(p);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n = 1'b0; en = 1'b1; sym_vld = 1'b0; sym_data = 1'b0; frm_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_vld", 32'(frm_vld), 32'd0);
    chk("rst_data", 32'(frm_data), 32'd0);
    chk("rst_err", 32'(frm_err), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cyc(2);

    // Golden frame: 0xA5 with even parity 0.
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b0);
    idle_cyc(3);
    chk("golden_drained", 32'(exp_q.size()), 32'd0);

    // Parity error: same payload, wrong parity bit.
    exp_q.push_back({1'b1, 8'hA5});
    send_frame(8'hA5, 1'b1);
    idle_cyc(3);
    chk("parerr_drained", 32'(exp_q.size()), 32'd0);

    // Short sync: 1,1,1,0 must not start a frame.
    sym(1'b1); sym(1'b1); sym(1'b1); sym(1'b0);
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b0);
    idle_cyc(3);
    chk("shortsync_drained", 32'(exp_q.size()), 32'd0);

    // Timeout after 3 data bits and a 16-cycle gap, then a clean frame.
    send_head(8'hA5, 3);
    idle_cyc(TMO_TH);
    idle_cyc(3);
    chk("tmo_pulses", 32'(tmo_cnt), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b0);
    idle_cyc(3);
    chk("post_tmo_drained", 32'(exp_q.size()), 32'd0);

    // Overflow and backpressure.
    frm_rdy = 1'b0;
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b0);
    idle_cyc(2);
    send_frame(8'h3C, 1'b0);
    idle_cyc(3);
    chk("ovf_pulses", 32'(ovf_cnt), 32'd1);
    chk("held_vld", 32'(frm_vld), 32'd1);
    chk("held_data", 32'(frm_data), 32'hA5);
    exp_q.push_back({1'b0, 8'h3C});
    send_head(8'h3C, DATA_W);
    @(negedge clk);
    sym_vld = 1'b1; sym_data = 1'b0; frm_rdy = 1'b1;
    idle_cyc(3);
    chk("reload_ovf_pulses", 32'(ovf_cnt), 32'd1);
    chk("reload_drained", 32'(exp_q.size()), 32'd0);

    // Enable drop mid-DATA while a frame is held in the buffer.
    frm_rdy = 1'b0;
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b0);
    send_head(8'h3C, 2);
    @(negedge clk);
    en = 1'b0; sym_vld = 1'b1; sym_data = 1'b1;
    @(negedge clk);
    sym_vld = 1'b0;
    #1;
    chk("en_busy", 32'(busy), 32'd0);
    idle_cyc(TMO_TH + 4);
    chk("en_no_tmo", 32'(tmo_cnt), 32'd1);
    chk("en_held_vld", 32'(frm_vld), 32'd1);
    frm_rdy = 1'b1;
    idle_cyc(2);
    chk("en_drained", 32'(exp_q.size()), 32'd0);
    en = 1'b1;
    idle_cyc(2);

    // Asynchronous reset mid-frame, then a clean frame.
    send_head(8'hA5, 2);
    @(negedge clk);
    sym_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_vld", 32'(frm_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cyc(2);
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b0);
    idle_cyc(3);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_owt_rx_ctrl

// File: doc/owt_rx_ctrl.md
# owt_rx_ctrl

- Receive-side frame controller for the one-wire-transfer (OWT) link.
- Consumes the debounced symbol stream from the upstream run-length symbol detector (one `vld`/`data` pulse per decoded 0/1 symbol).
- Sequences sync hunt, data-bit capture and parity check, and hands complete frames to the register/decode logic over a valid/ready handshake with a one-entry output buffer.
- Flags parity errors, inter-symbol timeouts and output overflows.

## Interface
- `DATA_W`, 8: payload bits per frame, sent MSB first.
- `SYNC_LEN`, 4: minimum number of consecutive `1` symbols forming the sync preamble.
- `TMO_W`, 12: width of the inter-symbol gap counter.
- `TMO_TH`, `TMO_W'(1000)`: gap length in cycles that aborts a frame; must be ≥1.

Ports:
- `i_clk`  in  1: the single clock of the block.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_en`  in  1: controller enable; low forces the hunt state.
- `i_sym_vld`  in  1: single-cycle symbol strobe from the detector.
- `i_sym_data`  in  1: symbol value, qualified by `i_sym_vld`.
- `o_frm_vld`  out  1: output frame valid.
- `o_frm_data`  out  `DATA_W`: frame payload.
- `o_frm_err`  out  1: parity error flag, qualified by `o_frm_vld`.
- `i_frm_rdy`  in  1: consumer accepts the frame when `o_frm_vld & i_frm_rdy`.
- `o_tmo`  out  1: one-cycle pulse, frame aborted by timeout.
- `o_ovf`  out  1: one-cycle pulse, completed frame dropped because the buffer was full.
- `o_busy`  out  1: high whenever state ≠ HUNT.

## Operation
- FSM states: HUNT, DATA, PAR.
- **HUNT**
  - `sync_cnt` increments on each `1` symbol and saturates at `SYNC_LEN`.
  - A `0` symbol with `sync_cnt == SYNC_LEN` is the start bit: go to DATA with `bit_cnt = 0` and clear the shift register.
  - A `0` symbol with `sync_cnt < SYNC_LEN` clears `sync_cnt`.
  - No timeout in HUNT.
- **DATA**
  - Each symbol shifts into `shreg` LSB-side, so the first received bit ends up as the MSB.
  - `bit_cnt` increments on each symbol. On the symbol where `bit_cnt == DATA_W-1`, go to PAR.
- **PAR**
  - The next symbol is the even-parity bit.
  - `err = (^shreg) != sym`.
  - Buffer load: if the buffer is free (`!o_frm_vld`, or `o_frm_vld & i_frm_rdy` in the same cycle), load `o_frm_data = shreg` and `o_frm_err = err`, and set `o_frm_vld`.
  - If the buffer is not free, drop the frame, pulse `o_ovf`, and leave the buffer unchanged.
  - In either case go to HUNT with `sync_cnt = 0`.
- **Timeout** (DATA/PAR only)
  - `gap_cnt` clears on every `i_sym_vld` and on state entry, otherwise increments.
  - When `gap_cnt == TMO_TH-1` and `!i_sym_vld`: pulse `o_tmo` and go to HUNT with `sync_cnt = 0`.
- **Output buffer**: `o_frm_vld` clears on `o_frm_vld & i_frm_rdy` unless reloaded in the same cycle. While `o_frm_vld` is high, data and err stay stable.
- **`i_en` low**: synchronously forces HUNT and clears `sync_cnt`, `bit_cnt`, `gap_cnt` and `shreg`. Symbols are ignored and no `o_tmo` or `o_ovf` pulse occurs. The output buffer and handshake continue to operate.
- **Width rules**
  - `bit_cnt` is `$clog2(DATA_W)` bits wide.
  - `sync_cnt` is `$clog2(SYNC_LEN+1)` bits wide and never wraps.
  - `gap_cnt` stops at `TMO_TH-1` and never wraps.

## Timing
- Reset values: `o_frm_vld = 0`, `o_frm_data = 0`, `o_frm_err = 0`, `o_tmo = 0`, `o_ovf = 0`, `o_busy = 0`. State = HUNT and all counters = 0.
- `o_frm_vld` rises 1 cycle after the clock edge sampling the parity symbol.
- `o_tmo` and `o_ovf` are registered and asserted in the cycle after the triggering condition, for exactly one cycle.
- **Simultaneous events**
  - `i_sym_vld` in the cycle `gap_cnt` reaches `TMO_TH-1`: the symbol wins and no timeout occurs.
  - Parity symbol in the same cycle as acceptance of the previous frame: the new frame is loaded, `o_frm_vld` stays high, and there is no overflow.
  - `i_en` low with `i_sym_vld`: `i_en` wins.
- Back-to-back symbols on consecutive cycles are fully supported, one symbol per cycle.
- Reset asserted mid-frame: all state is lost immediately (asynchronous). After release the block starts in HUNT.

## Structure
- Package `owt_rx_pkg`:
  - `typedef enum logic [1:0] {HUNT, DATA, PAR} owt_rx_st_e`.
  - Parity-select constant `OWT_PAR_EVEN = 1'b1`; odd parity is reserved for future use.
- Single module, no sub-module. Three `always_ff` groups: FSM plus counters, shift register, output buffer plus status pulses.
- Assertions under `ASSERT_ON`:
  - `TMO_TH >= 1` and `SYNC_LEN >= 1`.
  - `o_frm_data` and `o_frm_err` are stable while `o_frm_vld & !i_frm_rdy`.

## Test plan
- Golden frame (`DATA_W=8`, `SYNC_LEN=4`, `i_frm_rdy=1`): symbols 1,1,1,1,0, then 1,0,1,0,0,1,0,1, then parity 0. Expect `o_frm_vld` for 1 cycle, `o_frm_data = 8'hA5`, `o_frm_err = 0`.
- Parity error: the same frame with parity symbol 1. Expect `o_frm_data = 8'hA5`, `o_frm_err = 1`.
- Short sync: 1,1,1,0 followed by a full golden frame. The first 0 must not start a frame; exactly one frame, 0xA5, is output.
- Timeout (`TMO_TH=16`): sync plus start plus 3 data bits, then idle for 16 cycles. Expect `o_tmo` pulse, `o_busy` low, no frame. A subsequent golden frame is received correctly.
- Overflow and backpressure: `i_frm_rdy = 0`, send 0xA5 then 0x3C. Expect the buffer to hold 0xA5 and `o_ovf` to pulse once. Raising `i_frm_rdy` in the same cycle as a third frame's (0x3C) parity symbol loads 0x3C with no `o_ovf`.
- `i_en` deassert mid-DATA: expect immediate HUNT, no `o_tmo`, and a held output frame still delivered on `i_frm_rdy`.
